instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 143 ++++++++++++++
 tb/tb_instr_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory, verifies a trailing XOR checksum and releases the CPU.
module instr_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StCsum,
        StDone,
        StError
    } loadState_e;

    loadState_e            stateQ, stateD;
    logic [15:0]           countQ, countD;
    logic [31:0]           asmQ, asmD;
    logic [7:0]            xorQ, xorD;
    logic [1:0]            byteIdxQ, byteIdxD;
    logic [ADDR_WIDTH:0]   wordCntQ, wordCntD;
    logic                  memWeQ, memWeD;
    logic [ADDR_WIDTH-1:0] memAddrQ, memAddrD;
    logic [31:0]           memWdataQ, memWdataD;

    logic        accept;
    logic [31:0] asmNext;
    logic [31:0] headerCount;
    logic [31:0] wordsIssued;

    assign in_ready  = (stateQ != StDone) && (stateQ != StError);
    assign accept    = in_valid && in_ready;
    assign cpu_hold  = (stateQ != StDone);
    assign done      = (stateQ == StDone);
    assign error     = (stateQ == StError);
    assign mem_we    = memWeQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;

    assign asmNext     = {asmQ[23:0], in_data};
    assign headerCount = {16'd0, countQ[15:8], in_data};
    // Words written once the current write issues; compared against N to leave DATA.
    assign wordsIssued = 32'(wordCntQ) + 32'd1;

    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        asmD      = asmQ;
        xorD      = xorQ;
        byteIdxD  = byteIdxQ;
        wordCntD  = wordCntQ;
        memWeD    = 1'b0;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;

        case (stateQ)
            StHdr0: begin
                if (accept) begin
                    countD[15:8] = in_data;
                    xorD         = xorQ ^ in_data;
                    stateD       = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    countD[7:0] = in_data;
                    xorD        = xorQ ^ in_data;
                    if (headerCount > Depth) begin
                        stateD = StError;
                    end else if (headerCount == 32'd0) begin
                        stateD = StCsum;
                    end else begin
                        stateD = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asmD     = asmNext;
                    xorD     = xorQ ^ in_data;
                    byteIdxD = byteIdxQ + 2'd1;
                    if (byteIdxQ == 2'd3) begin
                        memWeD    = 1'b1;
                        memAddrD  = wordCntQ[ADDR_WIDTH-1:0];
                        memWdataD = asmNext;
                        wordCntD  = wordCntQ + 1'b1;
                        if (wordsIssued == 32'(countQ)) begin
                            stateD = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    stateD = (in_data == xorQ) ? StDone : StError;
                end
            end
            default: begin
                // DONE and ERROR are terminal; only reset leaves them.
                stateD = stateQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StHdr0;
            countQ    <= '0;
            asmQ      <= '0;
            xorQ      <= '0;
            byteIdxQ  <= '0;
            wordCntQ  <= '0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            stateQ    <= stateD;
            countQ    <= countD;
            asmQ      <= asmD;
            xorQ      <= xorD;
            byteIdxQ  <= byteIdxD;
            wordCntQ  <= wordCntD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: nominal, bad checksum, oversize,
// boundary counts, stalls and reset mid-load.
module tb_instr_loader;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int compared;
    int mismatched;

    logic [AW+31:0] wq[$];

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each mem_we cycle contains exactly one falling edge, so one entry per pulse.
    always @(negedge clk) begin
        if (rst && mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic doReset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wq.delete();
    endtask

    // Called 1ns after a rising edge; returns 1ns after the edge accepting the last byte.
    task automatic sendStream(input logic [7:0] bytes[$], input int stall);
        for (int i = 0; i < bytes.size(); i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (stall > 0 && i != bytes.size() - 1) begin
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic checkNominal(input string tag);
        compared++;
        if (wq.size() !== 2) begin
            mismatched++;
            $display("FAIL %s write_count: got %0d want 2", tag, wq.size());
        end
        if (wq.size() >= 1) begin
            compared++;
            if (wq[0] !== {8'd0, 32'h20080005}) begin
                mismatched++;
                $display("FAIL %s write0: got %h want %h", tag, wq[0], {8'd0, 32'h20080005});
            end
        end
        if (wq.size() >= 2) begin
            compared++;
            if (wq[1] !== {8'd1, 32'h00000000}) begin
                mismatched++;
                $display("FAIL %s write1: got %h want %h", tag, wq[1], {8'd1, 32'h0});
            end
        end
        compared++;
        if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
            mismatched++;
            $display("FAIL %s status{done,error,hold,ready}: got %b want 1000", tag,
                     {done, error, cpu_hold, in_ready});
        end
    endtask

    task automatic test_reset();
        doReset();
        compared++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !==
            {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        end
    endtask

    task automatic test_nominal();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
        doReset();
        sendStream(s, 0);
        checkNominal("nominal");
        // Bytes offered after DONE must be ignored; write registers keep their values.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        compared++;
        if ({done, in_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 8'd1, 32'd0}) begin
            mismatched++;
            $display("FAIL nominal_after_done: done=%b ready=%b we=%b addr=%h wdata=%h",
                     done, in_ready, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2E};
        doReset();
        sendStream(s, 0);
        compared++;
        if (wq.size() !== 2) begin
            mismatched++;
            $display("FAIL badcsum_writes: got %0d want 2", wq.size());
        end
        compared++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
            mismatched++;
            $display("FAIL badcsum_status{done,error,hold,ready}: got %b want 0110",
                     {done, error, cpu_hold, in_ready});
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        s = '{8'h01, 8'h01};
        doReset();
        sendStream(s, 0);
        compared++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
            mismatched++;
            $display("FAIL oversize_status{done,error,hold,ready}: got %b want 0110",
                     {done, error, cpu_hold, in_ready});
        end
        in_valid = 1'b1;
        in_data  = 8'h11;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        compared++;
        if (wq.size() !== 0 || error !== 1'b1) begin
            mismatched++;
            $display("FAIL oversize_no_write: writes=%0d error=%b want 0 and 1", wq.size(), error);
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00, 8'h00};
        doReset();
        sendStream(s, 0);
        compared++;
        if ({done, error, cpu_hold} !== 3'b100 || wq.size() !== 0) begin
            mismatched++;
            $display("FAIL zero_count: done=%b err=%b hold=%b writes=%0d want 1 0 0 0",
                     done, error, cpu_hold, wq.size());
        end
    endtask

    task automatic test_full_depth();
        logic [7:0]  s[$];
        logic [7:0]  x;
        logic [31:0] w;
        int          bad;
        s = '{8'h01, 8'h00};
        for (int k = 0; k < 256; k++) begin
            w = {8'(k), ~8'(k), 8'(k) ^ 8'h5A, 8'hC3};
            s.push_back(w[31:24]);
            s.push_back(w[23:16]);
            s.push_back(w[15:8]);
            s.push_back(w[7:0]);
        end
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
        s.push_back(x);
        doReset();
        sendStream(s, 0);
        compared++;
        if (wq.size() !== 256) begin
            mismatched++;
            $display("FAIL full_write_count: got %0d want 256", wq.size());
        end
        bad = 0;
        for (int k = 0; k < 256 && k < wq.size(); k++) begin
            w = {8'(k), ~8'(k), 8'(k) ^ 8'h5A, 8'hC3};
            compared++;
            if (wq[k] !== {8'(k), w}) begin
                mismatched++;
                if (bad < 4) $display("FAIL full_write%0d: got %h want %h", k, wq[k], {8'(k), w});
                bad++;
            end
        end
        compared++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            mismatched++;
            $display("FAIL full_status{done,error,hold}: got %b want 100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_stalls();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
        doReset();
        sendStream(s, 3);
        checkNominal("stalls");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s[$];
        logic [7:0] head[$];
        s    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
        head = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        doReset();
        sendStream(head, 0);
        compared++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h20080005) begin
            mismatched++;
            $display("FAIL midload_pre_write: we=%b wdata=%h want 1 20080005", mem_we, mem_wdata);
        end
        rst = 1'b0;
        #1;
        compared++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !==
            {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL midload_async_reset: ready=%b we=%b addr=%h wdata=%h hold=%b done=%b",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        wq.delete();
        sendStream(s, 0);
        checkNominal("midload_reload");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        #2;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_oversize();
        test_zero_count();
        test_full_depth();
        test_stalls();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
